// File: rtl/bcd_event_counter.sv
// Multi-digit BCD accumulator for upstream decade-stage carry pulses,
// with run/hold/clear FSM, compare match, overflow and snapshot handshake.
module bcd_event_counter #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 4 * DIGITS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             cmp_en,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic             snap,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] bcd_cnt,
    output logic [1:0]       state,
    output logic             match,
    output logic             wrap,
    output logic             ovf,
    output logic [CNT_W-1:0] snap_bcd,
    output logic             snap_valid,
    output logic             snap_lost
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] inc;
    logic             all9;
    logic             carry;
    logic [3:0]       d;
    logic             cnt_en;
    logic             cnt_chg;

    assign state  = cur;
    // stop and clear both swallow a coincident tick
    assign cnt_en = (cur == RUN) && tick_in && !clear && !stop;

    always_comb begin
        nxt = cur;
        priority case (1'b1)
            clear:                nxt = IDLE;
            stop && cur == RUN:   nxt = HOLD;
            start && cur != RUN:  nxt = RUN;
            default:              nxt = cur;
        endcase
    end

    always_comb begin
        inc   = '0;
        carry = 1'b1;
        d     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = bcd_cnt[4*k +: 4];
            if (carry && d == 4'd9) begin
                inc[4*k +: 4] = 4'd0;
            end else if (carry) begin
                inc[4*k +: 4] = d + 4'd1;
                carry         = 1'b0;
            end else begin
                inc[4*k +: 4] = d;
            end
        end
        all9 = carry;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur     <= IDLE;
            bcd_cnt <= '0;
            wrap    <= 1'b0;
            ovf     <= 1'b0;
            cnt_chg <= 1'b0;
            match   <= 1'b0;
        end else begin
            cur     <= nxt;
            wrap    <= cnt_en && all9;
            cnt_chg <= cnt_en;
            // compare the value made visible by the previous counted tick
            match   <= cnt_chg && cmp_en && (bcd_cnt == cmp_val);
            if (clear) begin
                bcd_cnt <= '0;
                ovf     <= 1'b0;
            end else if (cnt_en) begin
                bcd_cnt <= inc;
                if (all9) ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_bcd   <= '0;
            snap_valid <= 1'b0;
            snap_lost  <= 1'b0;
        end else if (snap) begin
            snap_bcd   <= bcd_cnt;
            snap_valid <= 1'b1;
            if (snap_valid && !snap_ack) snap_lost <= 1'b1;
        end else if (snap_ack) begin
            snap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed plus random checks of bcd_event_counter against an
// integer-valued reference model.
module tb_bcd_event_counter;

    localparam int DIGITS = 4;
    localparam int CNT_W  = 16;
    localparam int MODV   = 10000;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             tick_in = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic             cmp_en = 1'b0;
    logic [CNT_W-1:0] cmp_val = '0;
    logic             snap = 1'b0;
    logic             snap_ack = 1'b0;
    logic [CNT_W-1:0] bcd_cnt;
    logic [1:0]       state;
    logic             match;
    logic             wrap;
    logic             ovf;
    logic [CNT_W-1:0] snap_bcd;
    logic             snap_valid;
    logic             snap_lost;

    int errors = 0;
    int checks = 0;

    int   m_cnt, m_state, m_snap;
    logic m_match, m_wrap, m_ovf, m_sv, m_sl, m_chg;
    int   match_seen;

    bcd_event_counter #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rstn(rstn), .tick_in(tick_in),
        .start(start), .stop(stop), .clear(clear),
        .cmp_en(cmp_en), .cmp_val(cmp_val),
        .snap(snap), .snap_ack(snap_ack),
        .bcd_cnt(bcd_cnt), .state(state), .match(match),
        .wrap(wrap), .ovf(ovf), .snap_bcd(snap_bcd),
        .snap_valid(snap_valid), .snap_lost(snap_lost)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] tobcd(input int v);
        logic [CNT_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_state = 0; m_snap = 0;
        m_match = 0; m_wrap = 0; m_ovf = 0;
        m_sv = 0; m_sl = 0; m_chg = 0;
    endtask

    task automatic chk_all();
        chk("bcd_cnt", 32'(bcd_cnt), 32'(tobcd(m_cnt)));
        chk("state", 32'(state), 32'(m_state));
        chk("match", 32'(match), 32'(m_match));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("snap_bcd", 32'(snap_bcd), 32'(tobcd(m_snap)));
        chk("snap_valid", 32'(snap_valid), 32'(m_sv));
        chk("snap_lost", 32'(snap_lost), 32'(m_sl));
    endtask

    task automatic step(input logic t, input logic st, input logic sp,
                        input logic cl, input logic sn, input logic ak);
        logic counted;
        int   pre;
        tick_in = t; start = st; stop = sp;
        clear = cl; snap = sn; snap_ack = ak;
        @(posedge clk);
        pre     = m_cnt;
        counted = (m_state == 1) && t && !cl && !sp;
        m_match = m_chg && cmp_en && (tobcd(m_cnt) == cmp_val);
        m_chg   = counted;
        m_wrap  = counted && (m_cnt == MODV - 1);
        if (cl) begin
            m_cnt = 0;
            m_ovf = 0;
        end else if (counted) begin
            if (m_cnt == MODV - 1) m_ovf = 1;
            m_cnt = (m_cnt + 1) % MODV;
        end
        if (cl) m_state = 0;
        else if (sp && m_state == 1) m_state = 2;
        else if (st && m_state != 1) m_state = 1;
        if (sn) begin
            if (m_sv && !ak) m_sl = 1;
            m_snap = pre;
            m_sv   = 1;
        end else if (ak) begin
            m_sv = 0;
        end
        #1;
        chk_all();
        if (match) match_seen++;
        tick_in = 0; start = 0; stop = 0;
        clear = 0; snap = 0; snap_ack = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all();
        chk("reset_cnt", 32'(bcd_cnt), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // plan 1
        step(1, 1, 0, 0, 0, 0);
        ticks(10);
        chk("p1_cnt", 32'(bcd_cnt), 32'h0010);
        chk("p1_state", 32'(state), 32'h1);

        // plan 2
        cmp_en = 1; cmp_val = 16'h9999;
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        match_seen = 0;
        ticks(9999);
        chk("p2_at9999", 32'(bcd_cnt), 32'h9999);
        chk("p2_nomatch_yet", 32'(match_seen), 32'd0);
        ticks(1);
        chk("p2_wrap_cnt", 32'(bcd_cnt), 32'h0);
        chk("p2_wrap", 32'(wrap), 32'h1);
        chk("p2_ovf", 32'(ovf), 32'h1);
        chk("p2_match_once", 32'(match_seen), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("p2_clr_ovf", 32'(ovf), 32'h0);
        chk("p2_clr_state", 32'(state), 32'h0);
        cmp_en = 0;

        // plan 3
        step(0, 1, 0, 0, 0, 0);
        ticks(42);
        step(1, 0, 1, 0, 0, 0);
        chk("p3_stop_cnt", 32'(bcd_cnt), 32'h0042);
        ticks(5);
        chk("p3_hold_cnt", 32'(bcd_cnt), 32'h0042);
        step(0, 1, 0, 0, 0, 0);
        ticks(1);
        chk("p3_final", 32'(bcd_cnt), 32'h0043);

        // plan 4
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        ticks(127);
        step(1, 0, 0, 0, 1, 0);
        chk("p4_snap", 32'(snap_bcd), 32'h0127);
        chk("p4_cnt", 32'(bcd_cnt), 32'h0128);
        chk("p4_valid", 32'(snap_valid), 32'h1);
        step(0, 0, 0, 0, 1, 0);
        chk("p4_lost", 32'(snap_lost), 32'h1);
        step(0, 0, 0, 0, 0, 1);
        chk("p4_ack", 32'(snap_valid), 32'h0);

        // plan 5
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        ticks(300);
        step(0, 1, 1, 1, 0, 0);
        chk("p5_state", 32'(state), 32'h0);
        ticks(3);
        chk("p5_cnt", 32'(bcd_cnt), 32'h0);

        // random phase
        cmp_en = 1; cmp_val = 16'h0007;
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 4) == 0));
        end

        // plan 6
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        ticks(555);
        step(0, 0, 0, 0, 1, 0);
        chk("p6_pre_cnt", 32'(bcd_cnt), 32'h0555);
        chk("p6_pre_valid", 32'(snap_valid), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rstn = 1'b1;
        step(1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
